// File: rtl/priority_arbiter_rr_pkg.sv
// Shared constants, FSM encoding and width helper for the priority_arbiter_rr block.
package priority_arbiter_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/priority_arbiter_rr_find.sv
// Combinational highest-set-bit finder: reports whether any bit is set and its index.
module priority_arbiter_rr_find
    import priority_arbiter_rr_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter with fixed-priority and round-robin modes behind a valid/ready grant port.
module priority_arbiter_rr
    import priority_arbiter_rr_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_eff;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] masked_idx;
    logic [IDX_W-1:0] raw_idx;
    logic [N-1:0]     below_mask;
    logic             masked_found;
    logic             raw_found;
    logic             accept;
    logic             arb;

    assign gnt_valid = (state == ST_HOLD);
    assign accept    = gnt_valid & gnt_ready;
    assign arb       = (state == ST_IDLE) || gnt_ready;

    // The grant being accepted this cycle is already the last winner for back-to-back searches.
    assign ptr_eff = accept ? gnt_idx : ptr;

    always_comb begin
        below_mask = '0;
        for (int i = 0; i < N; i++) begin
            below_mask[i] = (IDX_W'(i) < ptr_eff);
        end
    end

    priority_arbiter_rr_find #(.N(N), .IDX_W(IDX_W)) u_find_masked (
        .vec   (req & below_mask),
        .found (masked_found),
        .idx   (masked_idx)
    );

    priority_arbiter_rr_find #(.N(N), .IDX_W(IDX_W)) u_find_raw (
        .vec   (req),
        .found (raw_found),
        .idx   (raw_idx)
    );

    // Round-robin prefers indices below ptr; with none set it wraps to the top of the raw vector.
    always_comb begin
        winner = raw_idx;
        case (mode)
            MODE_FIXED: winner = raw_idx;
            MODE_RR:    if (masked_found) winner = masked_idx;
        endcase
    end

    always_comb begin
        state_next = state;
        if (arb) begin
            state_next = raw_found ? ST_HOLD : ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            if (accept) begin
                ptr <= gnt_idx;
            end
            if (arb) begin
                gnt_idx    <= raw_found ? winner : '0;
                gnt_onehot <= raw_found ? (N'(1) << winner) : '0;
            end
        end
    end

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Scoreboard bench for priority_arbiter_rr (N=16): directed vectors push expectations, a monitor checks.
module tb_priority_arbiter_rr;

    localparam int N = 16;

    typedef struct {
        int   cyc;
        int   tag;
        logic valid;
        int   idx;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          mode;
    logic          gnt_ready;
    logic          gnt_valid;
    logic [3:0]    gnt_idx;
    logic [N-1:0]  gnt_onehot;

    int   cyc;
    int   n_tests;
    int   n_fail;
    int   phase;
    exp_t exp_q[$];

    priority_arbiter_rr #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic [N-1:0] r, input logic m, input logic rdy,
                        input logic ev, input int ei);
        exp_t e;
        @(negedge clk);
        req       = r;
        mode      = m;
        gnt_ready = rdy;
        e.cyc   = cyc + 1;
        e.tag   = phase;
        e.valid = ev;
        e.idx   = ei;
        exp_q.push_back(e);
    endtask

    // Monitor: pops every expectation whose edge has passed and compares the presented outputs.
    initial begin
        exp_t         e;
        logic [N-1:0] one;
        logic [N-1:0] exp_oh;
        one = 1;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                exp_oh = e.valid ? (one << e.idx) : '0;
                check($sformatf("t%0d_c%0d_valid", e.tag, e.cyc), 32'(gnt_valid), 32'(e.valid));
                check($sformatf("t%0d_c%0d_idx", e.tag, e.cyc), 32'(gnt_idx),
                      e.valid ? 32'(e.idx) : 32'd0);
                check($sformatf("t%0d_c%0d_onehot", e.tag, e.cyc), 32'(gnt_onehot), 32'(exp_oh));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        phase     = 0;
        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        gnt_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_idx", 32'(gnt_idx), 32'd0);
        check("reset_onehot", 32'(gnt_onehot), 32'd0);
        rst = 1'b0;

        // Fixed priority, highest index wins, repeated every cycle.
        phase = 2;
        repeat (4) step(16'h4001, 1'b0, 1'b1, 1'b1, 14);

        // Asynchronous reset while a grant is being presented.
        @(negedge clk);
        check("pre_rst_valid", 32'(gnt_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(gnt_valid), 32'd0);
        check("async_rst_idx", 32'(gnt_idx), 32'd0);
        check("async_rst_onehot", 32'(gnt_onehot), 32'd0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;

        // No requests: stays idle.
        phase = 1;
        repeat (5) step(16'h0000, 1'b0, 1'b1, 1'b0, 0);

        // Round-robin over all requesters: 15 down to 0, then wraps to 15.
        phase = 3;
        for (int i = 0; i <= 16; i++) step(16'hFFFF, 1'b1, 1'b1, 1'b1, (31 - i) % 16);

        // Single request 0 brings ptr back to 0.
        phase = 40;
        step(16'h0001, 1'b1, 1'b1, 1'b1, 0);

        phase = 4;
        step(16'h8081, 1'b1, 1'b1, 1'b1, 15);
        step(16'h8081, 1'b1, 1'b1, 1'b1, 7);
        step(16'h8081, 1'b1, 1'b1, 1'b1, 0);
        step(16'h8081, 1'b1, 1'b1, 1'b1, 15);
        repeat (3) step(16'h0001, 1'b1, 1'b1, 1'b1, 0);

        // Stall holds grant 13 even after its request drops.
        phase = 5;
        step(16'h2080, 1'b1, 1'b1, 1'b1, 13);
        step(16'h2080, 1'b1, 1'b0, 1'b1, 13);
        step(16'h2080, 1'b1, 1'b0, 1'b1, 13);
        step(16'h0080, 1'b1, 1'b0, 1'b1, 13);
        step(16'h0080, 1'b1, 1'b0, 1'b1, 13);
        step(16'h0080, 1'b1, 1'b1, 1'b1, 7);

        // Mode switch keeps ptr.
        phase = 6;
        step(16'hFFFF, 1'b0, 1'b1, 1'b1, 15);
        step(16'hFFFF, 1'b1, 1'b1, 1'b1, 14);

        // Ready while idle is harmless; IDLE arbitrates regardless of ready; stall then release.
        phase = 7;
        step(16'h0000, 1'b1, 1'b1, 1'b0, 0);
        step(16'h0000, 1'b1, 1'b1, 1'b0, 0);
        step(16'h0004, 1'b1, 1'b0, 1'b1, 2);
        step(16'h0000, 1'b1, 1'b0, 1'b1, 2);
        step(16'h0000, 1'b1, 1'b1, 1'b0, 0);

        repeat (3) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
